rgb_pwm_bank: RTL and testbench
===============================

# rgb_pwm_bank

Multi-channel PWM generator driving the RGB LED drivers from one shared period counter. Each channel carries a double-buffered duty value. New duties are written at any time and take effect only at a period boundary, so the LED never sees a glitched or truncated pulse. The block is the parametrised successor of the single-channel PWM counter and sits between the mood/colour controller and the LED pins.

## Interface
- `CH`, default 3: number of PWM channels (R, G, B).
- `W`, default 16: width of each duty value and of the period counter.
- `PERIOD`, default 50000: counter period in clocks. Legal range is 2..2^W; the counter runs 0..PERIOD-1.

Ports (clock and reset first):
- `clk`  input  1: system clock. All logic is on the rising edge.
- `rst_n`  input  1: asynchronous active-low reset.
- `duty_in`  input  CH*W: packed duty values; channel i is `duty_in[i*W +: W]`.
- `load`  input  1: single-cycle strobe that captures `duty_in` into the shadow registers.
- `pwm`  output  CH: PWM outputs, registered.
- `period_end`  output  1: one-cycle pulse, registered, marking each period wrap.
- `pending`  output  1: high while a shadow value has not yet been fully applied.

## Operation
Counter:
- `cnt` (W bits) increments every clock.
- At PERIOD-1 it wraps to 0; this cycle is the "wrap cycle".

Shadow registers:
- `load`=1 sets `shadow[i]` <= `duty_in` slice for every channel, and `pending` <= 1.
- `load` is accepted every cycle and never stalls; the last load before a wrap wins.

Active registers:
- On a wrap cycle with `pending`=1, `active[i]` <= `shadow[i]` and `pending` <= 0.
- Exception: if `load`=1 in that same wrap cycle, `active` takes the old shadow, the shadow takes the new `duty_in`, and `pending` stays 1. The new value applies at the following wrap.

Output compare:
- `pwm[i]` <= (`cnt` < `active[i]`), compared unsigned.
- Duty 0 gives a constant low output.
- Duty >= PERIOD gives a constant high output. No separate clamp logic is needed for this.

Period pulse:
- `period_end` <= (`cnt` == PERIOD-1).

Reset mid-operation:
- All state clears immediately and asynchronously.
- Any pending shadow value is discarded.

## Timing
- Reset values: `cnt`=0, `shadow`=0, `active`=0, `pending`=0, `pwm`=0, `period_end`=0.
- `pwm` lags `cnt` by one clock. In steady state each period has exactly `active[i]` high clocks, starting the cycle after `cnt`=0.
- `period_end` is high for one clock, in the cycle where `cnt`=0 after a wrap.
- A new duty first affects `pwm` in the cycle after the wrap that applies it.
- Worst-case load-to-effect latency is PERIOD+1 clocks.
- `pending` rises the cycle after `load`. It falls the cycle after the applying wrap.

## Configuration
Macro: `RGB_PWM_FADE_EN`.

Defined:
- On each wrap where `active[i]` != `shadow[i]`, `active[i]` steps by exactly 1 toward `shadow[i]`.
- `pending` clears only at the wrap after which every channel equals its shadow.
- A `load` during a fade retargets the fade from the current active value.
- A full 0->N transition takes N periods.

Undefined:
- `active` jumps directly to `shadow` as described under Operation. No fade logic is synthesised.

## Test plan
Bench parameters: `CH`=3, `W`=8, `PERIOD`=10.
- Reset, then `load` duties {3,0,10} at cycle 2 -> `pwm` stays 0 until the first wrap. After it: ch0 is high 3 of every 10 clocks, ch1 is always low, ch2 is always high. `pending` falls one cycle after the wrap.
- Load 5, then load 7 before the wrap -> only 7 is applied. No period ever shows 5 high clocks.
- Load 4 exactly on the wrap cycle (`cnt`=9) while 2 is pending -> the next period shows 2 high clocks. The period after shows 4. `pending` stays high across the first wrap.
- Duty 255 (greater than PERIOD) -> ch0 is continuously high. `period_end` pulses every 10 clocks, high for 1 clock each time.
- Assert `rst_n` low mid-period with `pwm`=1 and a load pending -> `pwm`, `period_end` and `pending` go to 0 asynchronously. After release, the old duty does not reappear.
- With `RGB_PWM_FADE_EN`, load 0->4 on ch0 -> successive periods show 1, 2, 3, 4 high clocks. `pending` falls after the 4th wrap.

Source files
------------

// File: rtl/rgb_pwm_bank.sv
// Multi-channel PWM bank sharing one period counter, with double-buffered duty values.
// Optional macro RGB_PWM_FADE_EN: active duty ramps by one step per period toward the shadow.
module rgb_pwm_bank #(
    parameter int CH     = 3,
    parameter int W      = 16,
    parameter int PERIOD = 50000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH*W-1:0] duty_in,
    input  logic            load,
    output logic [CH-1:0]   pwm,
    output logic            period_end,
    output logic            pending
);
    localparam logic [W-1:0] LAST = W'(PERIOD - 1);
    localparam logic [W-1:0] ONE  = W'(1);

    logic [W-1:0]  r_cnt;
    logic [W-1:0]  r_shadow [CH];
    logic [W-1:0]  r_active [CH];
    logic          r_pending;
    logic [CH-1:0] r_pwm;
    logic          r_period_end;
    logic          w_wrap;

    assign w_wrap = (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_period_end <= 1'b0;
        end else begin
            r_cnt        <= w_wrap ? '0 : r_cnt + ONE;
            r_period_end <= w_wrap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < CH; i++) begin
                r_shadow[i] <= duty_in[i*W +: W];
            end
        end
    end

`ifdef RGB_PWM_FADE_EN
    logic [W-1:0] w_act_nxt [CH];
    logic         w_settled;

    // One-step move toward the shadow; settled means no channel needs another step.
    always_comb begin
        w_settled = 1'b1;
        for (int i = 0; i < CH; i++) begin
            w_act_nxt[i] = r_active[i];
            if (r_active[i] < r_shadow[i]) begin
                w_act_nxt[i] = r_active[i] + ONE;
            end else if (r_active[i] > r_shadow[i]) begin
                w_act_nxt[i] = r_active[i] - ONE;
            end
            if (w_act_nxt[i] != r_shadow[i]) begin
                w_settled = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                r_active[i] <= '0;
            end
            r_pending <= 1'b0;
        end else begin
            if (w_wrap) begin
                for (int i = 0; i < CH; i++) begin
                    r_active[i] <= w_act_nxt[i];
                end
            end
            if (load) begin
                r_pending <= 1'b1;
            end else if (w_wrap && w_settled) begin
                r_pending <= 1'b0;
            end
        end
    end
`else
    // A load on the wrap cycle still hands the old shadow to active and keeps pending set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                r_active[i] <= '0;
            end
            r_pending <= 1'b0;
        end else begin
            if (w_wrap && r_pending) begin
                for (int i = 0; i < CH; i++) begin
                    r_active[i] <= r_shadow[i];
                end
            end
            if (load) begin
                r_pending <= 1'b1;
            end else if (w_wrap) begin
                r_pending <= 1'b0;
            end
        end
    end
`endif

    // Duty >= PERIOD is always above the counter, so it saturates high without a clamp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                r_pwm[i] <= (r_cnt < r_active[i]);
            end
        end
    end

    assign pwm        = r_pwm;
    assign period_end = r_period_end;
    assign pending    = r_pending;

endmodule

// File: tb/tb_rgb_pwm_bank.sv
// Directed bench for rgb_pwm_bank (CH=3, W=8, PERIOD=10): per-period high counts, pulses and pending.
module tb_rgb_pwm_bank;
    localparam int CH     = 3;
    localparam int W      = 8;
    localparam int PERIOD = 10;

    logic            clk     = 1'b0;
    logic            rst_n   = 1'b0;
    logic [CH*W-1:0] duty_in = '0;
    logic            load    = 1'b0;
    logic [CH-1:0]   pwm;
    logic            period_end;
    logic            pending;

    int n_checks = 0;
    int n_fail   = 0;

    rgb_pwm_bank #(.CH(CH), .W(W), .PERIOD(PERIOD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .duty_in    (duty_in),
        .load       (load),
        .pwm        (pwm),
        .period_end (period_end),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one full period starting with cnt=0; load slot k is sampled on the edge where cnt=k.
    task automatic run_period(input string tag,
                              input int at1, input logic [CH*W-1:0] d1,
                              input int at2, input logic [CH*W-1:0] d2,
                              input int e0, input int e1, input int e2,
                              input int epre, input int epend);
        int h0, h1, h2, pe, pre;
        h0 = 0; h1 = 0; h2 = 0; pe = 0; pre = 0;
        for (int k = 0; k < PERIOD; k++) begin
            if (k == at1) begin
                duty_in = d1;
                load    = 1'b1;
            end else if (k == at2) begin
                duty_in = d2;
                load    = 1'b1;
            end else begin
                load = 1'b0;
            end
            tick();
            h0 += int'(pwm[0]);
            h1 += int'(pwm[1]);
            h2 += int'(pwm[2]);
            pe += int'(period_end);
            if (k == PERIOD - 2) pre = int'(pending);
        end
        load = 1'b0;
        check_val($sformatf("%s ch0_high", tag), h0, e0);
        check_val($sformatf("%s ch1_high", tag), h1, e1);
        check_val($sformatf("%s ch2_high", tag), h2, e2);
        check_val($sformatf("%s period_end_count", tag), pe, 1);
        check_val($sformatf("%s pending_before_wrap", tag), pre, epre);
        check_val($sformatf("%s pending_after_wrap", tag), int'(pending), epend);
    endtask

    initial begin
        tick();
        tick();
        check_val("reset pwm", int'(pwm), 0);
        check_val("reset period_end", int'(period_end), 0);
        check_val("reset pending", int'(pending), 0);
        rst_n = 1'b1;

`ifdef RGB_PWM_FADE_EN
        run_period("fade p1", 0, {8'd0, 8'd0, 8'd4}, -1, '0, 0, 0, 0, 1, 1);
        run_period("fade p2", -1, '0, -1, '0, 1, 0, 0, 1, 1);
        run_period("fade p3", -1, '0, -1, '0, 2, 0, 0, 1, 1);
        run_period("fade p4", -1, '0, -1, '0, 3, 0, 0, 1, 0);
        run_period("fade p5", -1, '0, -1, '0, 4, 0, 0, 0, 0);
`else
        // Load {3,0,10} at cnt=2: nothing visible until the first wrap.
        run_period("basic p1", 2, {8'd10, 8'd0, 8'd3}, -1, '0, 0, 0, 0, 1, 0);
        run_period("basic p2", -1, '0, -1, '0, 3, 0, 10, 0, 0);
        run_period("basic p3", -1, '0, -1, '0, 3, 0, 10, 0, 0);

        // Two loads in one period: the later one (7) wins.
        run_period("last_wins p1", 1, {8'd10, 8'd0, 8'd5}, 4, {8'd10, 8'd0, 8'd7},
                   3, 0, 10, 1, 0);
        run_period("last_wins p2", -1, '0, -1, '0, 7, 0, 10, 0, 0);

        // 2 pending, then 4 loaded on the wrap cycle itself.
        run_period("wrap_load p1", 3, {8'd10, 8'd0, 8'd2}, 9, {8'd10, 8'd0, 8'd4},
                   7, 0, 10, 1, 1);
        run_period("wrap_load p2", -1, '0, -1, '0, 2, 0, 10, 1, 0);
        run_period("wrap_load p3", -1, '0, -1, '0, 4, 0, 10, 0, 0);

        // Duty above PERIOD saturates high.
        run_period("sat p1", 0, {8'd10, 8'd0, 8'd255}, -1, '0, 4, 0, 10, 1, 0);
        run_period("sat p2", -1, '0, -1, '0, 10, 0, 10, 0, 0);
        run_period("sat p3", -1, '0, -1, '0, 10, 0, 10, 0, 0);

        // Asynchronous reset mid-period with pwm high and a load pending.
        duty_in = {8'd0, 8'd0, 8'd6};
        load    = 1'b1;
        tick();
        load = 1'b0;
        tick();
        check_val("pre_reset pwm0", int'(pwm[0]), 1);
        check_val("pre_reset pending", int'(pending), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_reset pwm", int'(pwm), 0);
        check_val("async_reset period_end", int'(period_end), 0);
        check_val("async_reset pending", int'(pending), 0);
        tick();
        tick();
        check_val("held_reset pwm", int'(pwm), 0);
        rst_n = 1'b1;
        run_period("post_reset p1", -1, '0, -1, '0, 0, 0, 0, 0, 0);
        run_period("post_reset p2", -1, '0, -1, '0, 0, 0, 0, 0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
